// File: rtl/break_value_counter.sv
// WalkSAT break-value evaluator: flags the clauses a candidate flip would break and
// registers both the flag vector and its population count, one clock after sampling.
module break_value_counter #(
  parameter int NUM_CLAUSES      = 20,
  parameter int NUM_ROWS         = 3,
  parameter int NUM_CLAUSES_BITS = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CLAUSES-1:0]      clause_broken_i,
  input  logic [NUM_CLAUSES-1:0]      mask_bits_i,
  output logic [NUM_CLAUSES_BITS-1:0] break_value_o,
  output logic [NUM_CLAUSES-1:0]      clause_broken_o
);

  localparam int SEG_W     = (NUM_CLAUSES + NUM_ROWS - 1) / NUM_ROWS;
  localparam int PAD_W     = SEG_W * NUM_ROWS;
  localparam int SEG_CNT_W = $clog2(SEG_W + 1);
  localparam int SUM_W     = $clog2(NUM_CLAUSES + 1);
  localparam int OUT_MAX   = (2 ** NUM_CLAUSES_BITS) - 1;

  logic [NUM_CLAUSES-1:0]      broken;
  logic [PAD_W-1:0]            broken_pad;
  logic [SEG_CNT_W-1:0]        seg_cnt [NUM_ROWS];
  logic [SUM_W-1:0]            sum;
  logic [NUM_CLAUSES_BITS-1:0] count_sat;

  assign broken = clause_broken_i & mask_bits_i;

  // The last segment is clipped; padding with constant zeros keeps the unused
  // positions of that segment from contributing anything but 0 to its count.
  assign broken_pad = PAD_W'(broken);

  // NOTE: every always_comb output gets a default before the loops so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    for (int k = 0; k < NUM_ROWS; k++) begin
      seg_cnt[k] = '0;
      for (int i = 0; i < SEG_W; i++) begin
        seg_cnt[k] = seg_cnt[k] + SEG_CNT_W'(broken_pad[k*SEG_W + i]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_ROWS; k++) begin
      sum = sum + SUM_W'(seg_cnt[k]);
    end
  end

  // Saturation logic only exists when the output is narrower than the full count.
  generate
    if (SUM_W > NUM_CLAUSES_BITS) begin : g_sat
      assign count_sat = (sum > SUM_W'(OUT_MAX)) ? '1 : sum[NUM_CLAUSES_BITS-1:0];
    end else begin : g_ext
      assign count_sat = NUM_CLAUSES_BITS'(sum);
    end
  endgenerate

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      break_value_o   <= '0;
      clause_broken_o <= '0;
    end else begin
      break_value_o   <= count_sat;
      clause_broken_o <= broken;
    end
  end

endmodule

// File: tb/tb_break_value_counter.sv
// Self-checking bench for break_value_counter: directed vector table, random
// complement/back-to-back vectors, and reset corner sequences.
module tb_break_value_counter;

  localparam int NC = 20;
  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] clause_broken_i;
  logic [NC-1:0] mask_bits_i;
  logic [NB-1:0] break_value_o;
  logic [NC-1:0] clause_broken_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [NC-1:0] status;
    logic [NC-1:0] mask;
    logic [NC-1:0] exp_broken;
    logic [NB-1:0] exp_count;
  } vec_t;

  break_value_counter #(
    .NUM_CLAUSES(NC), .NUM_ROWS(3), .NUM_CLAUSES_BITS(NB)
  ) dut (
    .clk(clk), .reset(reset),
    .clause_broken_i(clause_broken_i), .mask_bits_i(mask_bits_i),
    .break_value_o(break_value_o), .clause_broken_o(clause_broken_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one vector, clock it in, and check the registered result.
  task automatic apply(input logic [NC-1:0] s, input logic [NC-1:0] m,
                       input logic [NC-1:0] eb, input logic [NB-1:0] ec, input string name);
    clause_broken_i = s;
    mask_bits_i     = m;
    @(posedge clk);
    #1;
    check({name, ".broken"}, 32'(clause_broken_o), 32'(eb));
    check({name, ".count"},  32'(break_value_o),   32'(ec));
  endtask

  function automatic logic [NB-1:0] ref_count(input logic [NC-1:0] v);
    logic [NB-1:0] c = '0;
    for (int i = 0; i < NC; i++) c = c + NB'(v[i]);
    return c;
  endfunction

  vec_t tbl[10];

  initial begin
    logic [NC-1:0] s, m;

    tbl[0] = '{20'hFFFFF, 20'h00000, 20'h00000, 5'd0};
    tbl[1] = '{20'h00000, 20'h00000, 20'h00000, 5'd0};
    tbl[2] = '{20'hAAAAA, 20'h55555, 20'h00000, 5'd0};
    tbl[3] = '{20'hFFC00, 20'h003FF, 20'h00000, 5'd0};
    tbl[4] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 5'd20};
    tbl[5] = '{20'h0000F, 20'h000FF, 20'h0000F, 5'd4};
    tbl[6] = '{20'h12345, 20'hFFFFF, 20'h12345, 5'd7};
    tbl[7] = '{20'h80001, 20'h80001, 20'h80001, 5'd2};
    tbl[8] = '{20'hFFFFF, 20'h060C0, 20'h060C0, 5'd4};
    tbl[9] = '{20'hABCDE, 20'h0F0F0, 20'h0B0D0, 5'd6};

    // Reset held two cycles with zero inputs, then inputs change while still in reset.
    reset           = 1'b0;
    clause_broken_i = '0;
    mask_bits_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.broken", 32'(clause_broken_o), 32'h0);
    check("reset.count",  32'(break_value_o),   32'h0);
    apply(20'hFFFFF, 20'hFFFFF, 20'h00000, 5'd0, "reset_hold");

    // First edge with reset released produces a valid result.
    reset = 1'b1;
    apply(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 5'd20, "release");

    // Table vectors; before each edge the previous result must still be held.
    for (int i = 0; i < 10; i++) begin
      logic [NC-1:0] prev_b;
      logic [NB-1:0] prev_c;
      prev_b = (i == 0) ? 20'hFFFFF : tbl[i-1].exp_broken;
      prev_c = (i == 0) ? 5'd20     : tbl[i-1].exp_count;
      clause_broken_i = tbl[i].status;
      mask_bits_i     = tbl[i].mask;
      #1;
      check($sformatf("hold%0d.broken", i), 32'(clause_broken_o), 32'(prev_b));
      check($sformatf("hold%0d.count", i),  32'(break_value_o),   32'(prev_c));
      apply(tbl[i].status, tbl[i].mask, tbl[i].exp_broken, tbl[i].exp_count,
            $sformatf("vec%0d", i));
    end

    // Mask equal to the complement of status never breaks anything.
    for (int i = 0; i < 5; i++) begin
      s = NC'($urandom);
      apply(s, ~s, 20'h0, 5'd0, $sformatf("compl%0d", i));
    end

    // Back-to-back random pairs against a bit-serial reference count.
    for (int i = 0; i < 40; i++) begin
      s = NC'($urandom);
      m = NC'($urandom);
      apply(s, m, s & m, ref_count(s & m), $sformatf("rand%0d", i));
    end

    // Mid-stream reset pulse, then recovery one cycle after release.
    reset = 1'b0;
    apply(20'h12345, 20'hFFFFF, 20'h0, 5'd0, "midreset0");
    apply(20'hFFFFF, 20'hFFFFF, 20'h0, 5'd0, "midreset1");
    reset = 1'b1;
    apply(20'hABCDE, 20'h0F0F0, 20'h0B0D0, 5'd6, "resume0");
    apply(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 5'd20, "resume1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
